// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM states, baud select codes
// matching Uart_byte_tx, and a constant-evaluable ceil(log2) helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Bits needed to index 'value' items (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or after ptr wins.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld
);

  localparam int SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] idx;

  // Scan N positions starting at ptr, wrapping, and keep the first hit.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      idx = sum[ID_W-1:0];
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one Uart_byte_tx between N_REQ requesters.
// Optional frame locking (grant held until req_last) with UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DATA_W  = 8,
  parameter  int BAUD_W  = 3,
  parameter  int GAP_CYC = 0,
  localparam int ID_W    = clog2(N_REQ)
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [BAUD_W-1:0]       baud_cfg,
  output logic                    send_en,
  output logic [DATA_W-1:0]       databyte,
  output logic [BAUD_W-1:0]       baud_set,
  input  logic                    tx_done,
  input  logic                    uart_state,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  localparam int GAP_W = clog2(GAP_CYC + 2);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              send_q, send_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic              arb_vld;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic [ID_W-1:0]   ptr_next;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic unused_inputs;
  assign unused_inputs = uart_state;
`else
  logic unused_inputs;
  assign unused_inputs = ^{uart_state, req_last};
`endif

  rr_arbiter #(
    .N   (N_REQ),
    .ID_W(ID_W)
  ) u_rr (
    .req    (arb_req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .gnt_vld(arb_vld)
  );

  // Arbitration request mask, handshake, and muxed byte of the winner.
  always_comb begin
`ifdef UART_ARB_LOCK_EN
    arb_req = lock_q ? (req_valid & (N_REQ'(1) << gid_q)) : req_valid;
`else
    arb_req = req_valid;
`endif
    // Ready is held low during reset so a reset cycle never accepts a byte.
    xfer      = arb_vld && (state_q == ST_IDLE) && !sys_rst;
    req_ready = xfer ? arb_gnt : '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
    ptr_next = (arb_id == ID_W'(N_REQ - 1)) ? '0 : arb_id + ID_W'(1);
  end

  // Next-state logic for the IDLE/WAIT/GAP sequencer and latched outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    baud_d  = baud_q;
    send_d  = 1'b0;
    gap_d   = gap_q;
`ifdef UART_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          data_d  = sel_data;
          gid_d   = arb_id;
          baud_d  = baud_cfg;
          send_d  = 1'b1;
          state_d = ST_WAIT;
`ifdef UART_ARB_LOCK_EN
          if (req_last[arb_id]) begin
            lock_d = 1'b0;
            ptr_d  = ptr_next;
          end else begin
            lock_d = 1'b1;
          end
`else
          ptr_d   = ptr_next;
`endif
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (GAP_CYC > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(GAP_CYC - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      baud_q  <= '0;
      send_q  <= 1'b0;
      gap_q   <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      baud_q  <= baud_d;
      send_q  <= send_d;
      gap_q   <= gap_d;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign send_en  = send_q;
  assign databyte = data_q;
  assign baud_set = baud_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: table of per-byte transactions plus
// hand sequences for reset-in-WAIT, idle tx_done, GAP timing and frame locking.
module tb_uart_tx_arbiter;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [2:0]  baud;
    logic [1:0]  gid;
    logic [7:0]  exp_byte;
    int unsigned lat;
  } vec_t;

  logic        clk;
  logic        sys_rst;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [2:0]  baud_cfg, baud_set;
  logic        send_en, tx_done, uart_state, busy;
  logic [7:0]  databyte;
  logic [1:0]  grant_id;

  logic [3:0]  g_valid, g_ready;
  logic [31:0] g_req_data;
  logic [2:0]  g_baud_set;
  logic        g_send, g_done, g_busy;
  logic [7:0]  g_databyte;
  logic [1:0]  g_gid;

  int n_pass;
  int n_total;
  int step;

  vec_t main_tab[10];
  vec_t lock_tab[4];

  uart_tx_arbiter #(
    .N_REQ  (4),
    .DATA_W (8),
    .BAUD_W (3),
    .GAP_CYC(0)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .baud_cfg  (baud_cfg),
    .send_en   (send_en),
    .databyte  (databyte),
    .baud_set  (baud_set),
    .tx_done   (tx_done),
    .uart_state(uart_state),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  uart_tx_arbiter #(
    .N_REQ  (4),
    .DATA_W (8),
    .BAUD_W (3),
    .GAP_CYC(16)
  ) dut_gap (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .req_valid (g_valid),
    .req_data  (g_req_data),
    .req_last  (4'b1111),
    .req_ready (g_ready),
    .baud_cfg  (3'd1),
    .send_en   (g_send),
    .databyte  (g_databyte),
    .baud_set  (g_baud_set),
    .tx_done   (g_done),
    .uart_state(1'b0),
    .busy      (g_busy),
    .grant_id  (g_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, step, act, exp);
    end
  endtask

  // One full transaction: grant, send pulse, deferred baud, tx_done, back to IDLE.
  task automatic run_row(input vec_t v);
    @(negedge clk);
    req_valid = v.valid;
    req_data  = v.data;
    req_last  = v.last;
    baud_cfg  = v.baud;
    #1;
    check("ready_onehot", req_ready, 4'b0001 << v.gid);
    check("idle_busy", busy, 1'b0);
    @(negedge clk);
    check("send_pulse", send_en, 1'b1);
    check("databyte", databyte, v.exp_byte);
    check("baud_set", baud_set, v.baud);
    check("grant_id", grant_id, v.gid);
    check("wait_busy", busy, 1'b1);
    check("wait_ready", req_ready, 4'b0000);
    baud_cfg   = ~v.baud;
    uart_state = 1'b1;
    @(negedge clk);
    check("send_single", send_en, 1'b0);
    check("baud_deferred", baud_set, v.baud);
    repeat (v.lat) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done    = 1'b0;
    uart_state = 1'b0;
    req_valid  = 4'b0000;
    #1;
    check("done_busy", busy, 1'b0);
    check("byte_held", databyte, v.exp_byte);
  endtask

  initial begin
    int cnt;
    n_pass     = 0;
    n_total    = 0;
    step       = 0;
    sys_rst    = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    baud_cfg   = '0;
    tx_done    = 1'b0;
    uart_state = 1'b0;
    g_valid    = '0;
    g_req_data = 32'h4433_2211;
    g_done     = 1'b0;

    main_tab[0] = '{4'b0001, 4'b1111, 32'h1312_11aa, 3'd4, 2'd0, 8'haa, 3};
    main_tab[1] = '{4'b0010, 4'b1111, 32'h1312_1110, 3'd2, 2'd1, 8'h11, 5};
    main_tab[2] = '{4'b1111, 4'b1111, 32'h1312_1110, 3'd0, 2'd2, 8'h12, 2};
    main_tab[3] = '{4'b1111, 4'b1111, 32'h1312_1110, 3'd1, 2'd3, 8'h13, 4};
    main_tab[4] = '{4'b1111, 4'b1111, 32'h1312_1110, 3'd3, 2'd0, 8'h10, 1};
    main_tab[5] = '{4'b1111, 4'b1111, 32'h1312_1110, 3'd4, 2'd1, 8'h11, 6};
    main_tab[6] = '{4'b1001, 4'b1111, 32'h1312_1110, 3'd2, 2'd3, 8'h13, 2};
    main_tab[7] = '{4'b0110, 4'b1111, 32'h1312_1110, 3'd0, 2'd1, 8'h11, 3};
    main_tab[8] = '{4'b0011, 4'b1111, 32'h1312_1110, 3'd1, 2'd0, 8'h10, 2};
    main_tab[9] = '{4'b1000, 4'b1111, 32'h1312_1110, 3'd4, 2'd3, 8'h13, 1};

`ifdef UART_ARB_LOCK_EN
    lock_tab[0] = '{4'b0011, 4'b0010, 32'h0000_b0a0, 3'd4, 2'd0, 8'ha0, 2};
    lock_tab[1] = '{4'b0011, 4'b0010, 32'h0000_b0a1, 3'd4, 2'd0, 8'ha1, 2};
    lock_tab[2] = '{4'b0011, 4'b0011, 32'h0000_b0a2, 3'd4, 2'd0, 8'ha2, 2};
    lock_tab[3] = '{4'b0010, 4'b0010, 32'h0000_b0a2, 3'd4, 2'd1, 8'hb0, 2};
`else
    lock_tab[0] = '{4'b0011, 4'b0000, 32'h0000_b0a0, 3'd4, 2'd0, 8'ha0, 2};
    lock_tab[1] = '{4'b0011, 4'b0000, 32'h0000_b0a1, 3'd4, 2'd1, 8'hb0, 2};
    lock_tab[2] = '{4'b0001, 4'b0000, 32'h0000_b0a1, 3'd4, 2'd0, 8'ha1, 2};
    lock_tab[3] = '{4'b0001, 4'b0001, 32'h0000_b0a2, 3'd4, 2'd0, 8'ha2, 2};
`endif

    // Reset values
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    #1;
    check("rst_send", send_en, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_databyte", databyte, 8'h00);
    check("rst_baud", baud_set, 3'd0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);

    // Round-robin transaction table
    for (int i = 0; i < 10; i++) begin
      step = 100 + i;
      run_row(main_tab[i]);
    end

    // Reset in WAIT together with tx_done; pending request restarts from req0
    step = 200;
    @(negedge clk);
    req_valid = 4'b0010;
    req_data  = 32'h4433_2255;
    baud_cfg  = 3'd3;
    #1;
    check("rw_ready", req_ready, 4'b0010);
    @(negedge clk);
    check("rw_send", send_en, 1'b1);
    check("rw_grant", grant_id, 2'd1);
    req_valid = 4'b1111;
    @(negedge clk);
    sys_rst = 1'b1;
    tx_done = 1'b1;
    #1;
    check("rw_ready_in_rst", req_ready, 4'b0000);
    @(negedge clk);
    sys_rst = 1'b0;
    tx_done = 1'b0;
    #1;
    check("rw_rst_send", send_en, 1'b0);
    check("rw_rst_databyte", databyte, 8'h00);
    check("rw_rst_baud", baud_set, 3'd0);
    check("rw_rst_grant", grant_id, 2'd0);
    check("rw_rst_busy", busy, 1'b0);
    check("rw_regrant_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    check("rw_regrant_send", send_en, 1'b1);
    check("rw_regrant_id", grant_id, 2'd0);
    check("rw_regrant_byte", databyte, 8'h55);
    check("rw_regrant_baud", baud_set, 3'd3);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    check("rw_done_busy", busy, 1'b0);

    // tx_done while IDLE must not disturb anything
    step = 300;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    check("idle_done_busy", busy, 1'b0);
    check("idle_done_send", send_en, 1'b0);

    // GAP_CYC=16: count cycles from tx_done to next ready
    step = 400;
    @(negedge clk);
    g_valid = 4'b0011;
    #1;
    check("gap_ready0", g_ready, 4'b0001);
    @(negedge clk);
    check("gap_send0", g_send, 1'b1);
    check("gap_byte0", g_databyte, 8'h11);
    g_valid = 4'b0010;
    repeat (3) @(negedge clk);
    g_done = 1'b1;
    @(negedge clk);
    g_done = 1'b0;
    cnt    = 1;
    #1;
    check("gap_busy", g_busy, 1'b1);
    while (g_ready == 4'b0000 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      #1;
    end
    check("gap_cycles", cnt, 17);
    check("gap_ready1", g_ready, 4'b0010);
    @(negedge clk);
    g_valid = 4'b0000;
    check("gap_send1", g_send, 1'b1);
    check("gap_byte1", g_databyte, 8'h22);
    @(negedge clk);
    g_done = 1'b1;
    @(negedge clk);
    g_done = 1'b0;

    // Frame locking (or per-byte interleave without the lock feature)
    step = 500;
    @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step = 500 + i;
      run_row(lock_tab[i]);
`ifdef UART_ARB_LOCK_EN
      if (i == 0) begin
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("lock_hold", req_ready, 4'b0000);
      end
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
